// File: rtl/iterator_table_bank_pkg.sv
// Shared types and default sizes for the per-namespace iterator table bank.
package iterator_table_bank_pkg;

  localparam int NS_INDEX_ID_BITS_DEF  = 5;
  localparam int BASE_STRIDE_WIDTH_DEF = 32;
  localparam int DEPTH_DEF             = 32;

  // One base or stride word.
  typedef logic [BASE_STRIDE_WIDTH_DEF-1:0] iter_word_t;

  // Table entry index.
  typedef logic [NS_INDEX_ID_BITS_DEF-1:0] entry_idx_t;

  // Clear-sweep controller states.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/iterator_table_ram.sv
// Single table: DEPTH x DATA_W, one write port, one registered read port.
// Out-of-range writes are dropped; out-of-range reads return zero.
// With ITER_TABLE_BYPASS_EN defined, a same-cycle write to the read address
// is forwarded to the read data.
import iterator_table_bank_pkg::*;

module iterator_table_ram #(
  parameter int ADDR_W = NS_INDEX_ID_BITS_DEF,
  parameter int DATA_W = BASE_STRIDE_WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // One extra bit so the range compare never degenerates when DEPTH == 2**ADDR_W.
  localparam int                CMP_W   = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  DEPTH_C = CMP_W'(DEPTH);
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_word;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_C);

  // Select the word to be captured by the read register.
  always_comb begin
    rd_word = '0;
    if (rd_ok) rd_word = mem[rd_addr[IDX_W-1:0]];
`ifdef ITER_TABLE_BYPASS_EN
    if (rd_ok && wr_ok && (wr_addr == rd_addr)) rd_word = wr_data;
`endif
  end

  // Storage array, zeroed on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Read register: loads on an accepted read, otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= rd_word;
  end

endmodule

// File: rtl/iterator_table_bank.sv
// Per-namespace iterator bank: base and stride tables plus a DEPTH-cycle
// software clear sweep. During the sweep, external reads, writes and further
// clear requests are ignored.
// Optional: ITER_TABLE_BYPASS_EN forwards same-cycle write data to reads.
import iterator_table_bank_pkg::*;

module iterator_table_bank #(
  parameter int NS_INDEX_ID_BITS  = NS_INDEX_ID_BITS_DEF,
  parameter int BASE_STRIDE_WIDTH = BASE_STRIDE_WIDTH_DEF,
  parameter int DEPTH             = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_req,
  output logic                         busy,
  input  logic                         rd_req,
  input  logic [NS_INDEX_ID_BITS-1:0]  rd_addr,
  output logic                         rd_valid,
  output logic [BASE_STRIDE_WIDTH-1:0] rd_base,
  output logic [BASE_STRIDE_WIDTH-1:0] rd_stride,
  input  logic                         wr_base_req,
  input  logic [NS_INDEX_ID_BITS-1:0]  wr_base_addr,
  input  logic [BASE_STRIDE_WIDTH-1:0] wr_base_data,
  input  logic                         wr_stride_req,
  input  logic [NS_INDEX_ID_BITS-1:0]  wr_stride_addr,
  input  logic [BASE_STRIDE_WIDTH-1:0] wr_stride_data
);

  localparam logic [NS_INDEX_ID_BITS-1:0] LAST = NS_INDEX_ID_BITS'(DEPTH - 1);
  localparam logic [NS_INDEX_ID_BITS-1:0] ONE  = NS_INDEX_ID_BITS'(1);

  clr_state_e                    state_q, state_d;
  logic [NS_INDEX_ID_BITS-1:0]   cnt_q, cnt_d;
  logic                          sweep;
  logic                          rd_en;
  logic                          base_we, stride_we;
  logic [NS_INDEX_ID_BITS-1:0]   base_waddr, stride_waddr;
  logic [BASE_STRIDE_WIDTH-1:0]  base_wdata, stride_wdata;

  assign sweep = (state_q == CLEAR);
  assign busy  = sweep;
  assign rd_en = rd_req && !sweep;

  // While sweeping, the counter owns both write ports and writes zero.
  assign base_we      = sweep || wr_base_req;
  assign base_waddr   = sweep ? cnt_q : wr_base_addr;
  assign base_wdata   = sweep ? '0    : wr_base_data;
  assign stride_we    = sweep || wr_stride_req;
  assign stride_waddr = sweep ? cnt_q : wr_stride_addr;
  assign stride_wdata = sweep ? '0    : wr_stride_data;

  // Sweep state and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start on clear_req in IDLE, finish after entry DEPTH-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read valid follows an accepted read by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

  iterator_table_ram #(
    .ADDR_W (NS_INDEX_ID_BITS),
    .DATA_W (BASE_STRIDE_WIDTH),
    .DEPTH  (DEPTH)
  ) u_base (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (base_we),
    .wr_addr (base_waddr),
    .wr_data (base_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_base)
  );

  iterator_table_ram #(
    .ADDR_W (NS_INDEX_ID_BITS),
    .DATA_W (BASE_STRIDE_WIDTH),
    .DEPTH  (DEPTH)
  ) u_stride (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (stride_we),
    .wr_addr (stride_waddr),
    .wr_data (stride_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_stride)
  );

endmodule

// File: tb/tb_iterator_table_bank.sv
// Directed bench for iterator_table_bank. A second instance with DEPTH = 24
// shares the stimulus to cover the out-of-range address behaviour.
module tb_iterator_table_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic        wr_base_req, wr_stride_req;
  logic [4:0]  wr_base_addr, wr_stride_addr;
  logic [31:0] wr_base_data, wr_stride_data;

  logic        busy, rd_valid;
  logic [31:0] rd_base, rd_stride;
  logic        busy2, rd_valid2;
  logic [31:0] rd_base2, rd_stride2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iterator_table_bank #(.NS_INDEX_ID_BITS(5), .BASE_STRIDE_WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .reset(rst_n), .clear_req(clear_req), .busy(busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_base(rd_base), .rd_stride(rd_stride),
    .wr_base_req(wr_base_req), .wr_base_addr(wr_base_addr), .wr_base_data(wr_base_data),
    .wr_stride_req(wr_stride_req), .wr_stride_addr(wr_stride_addr), .wr_stride_data(wr_stride_data)
  );

  iterator_table_bank #(.NS_INDEX_ID_BITS(5), .BASE_STRIDE_WIDTH(32), .DEPTH(24)) dut24 (
    .clk(clk), .reset(rst_n), .clear_req(clear_req), .busy(busy2),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid2),
    .rd_base(rd_base2), .rd_stride(rd_stride2),
    .wr_base_req(wr_base_req), .wr_base_addr(wr_base_addr), .wr_base_data(wr_base_data),
    .wr_stride_req(wr_stride_req), .wr_stride_addr(wr_stride_addr), .wr_stride_data(wr_stride_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are stable afterwards and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 0; rd_req = 0; rd_addr = 0;
    wr_base_req = 0; wr_base_addr = 0; wr_base_data = 0;
    wr_stride_req = 0; wr_stride_addr = 0; wr_stride_data = 0;
  endtask

  task automatic wr_both(input logic [4:0] a, input logic [31:0] b, input logic [31:0] s);
    wr_base_req = 1; wr_base_addr = a; wr_base_data = b;
    wr_stride_req = 1; wr_stride_addr = a; wr_stride_data = s;
    tick();
    idle_inputs();
  endtask

  // Issue a read and leave the result on the outputs.
  task automatic rd(input logic [4:0] a);
    rd_req = 1; rd_addr = a;
    tick();
    idle_inputs();
  endtask

  initial begin
    int  n;
    bool_blk: begin end
  end

  initial begin
    int  n;
    logic vld_seen;
    idle_inputs();
    rst_n = 0;
    #23;
    chk("reset_busy",   64'(busy),      64'd0);
    chk("reset_vld",    64'(rd_valid),  64'd0);
    chk("reset_base",   64'(rd_base),   64'd0);
    chk("reset_stride", 64'(rd_stride), 64'd0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // Basic write then read.
    wr_both(5'd3, 32'h0000_1234, 32'hFFFF_FFFC);
    rd(5'd3);
    chk("rd3_vld",    64'(rd_valid),  64'd1);
    chk("rd3_base",   64'(rd_base),   64'h0000_1234);
    chk("rd3_stride", 64'(rd_stride), 64'hFFFF_FFFC);
    tick();
    chk("hold_vld",  64'(rd_valid), 64'd0);
    chk("hold_base", 64'(rd_base),  64'h0000_1234);

    // Same-cycle write and read to one address.
    wr_base_req = 1; wr_base_addr = 5'd7; wr_base_data = 32'h10;
    tick();
    idle_inputs();
    wr_base_req = 1; wr_base_addr = 5'd7; wr_base_data = 32'hA5A5_0001;
    rd_req = 1; rd_addr = 5'd7;
    tick();
    idle_inputs();
`ifdef ITER_TABLE_BYPASS_EN
    chk("rw7_base", 64'(rd_base), 64'hA5A5_0001);
`else
    chk("rw7_base", 64'(rd_base), 64'h10);
`endif
    chk("rw7_stride", 64'(rd_stride), 64'd0);
    rd(5'd7);
    chk("reread7_base", 64'(rd_base), 64'hA5A5_0001);

    // Base and stride write to the same address in one cycle.
    wr_both(5'd9, 32'h1111_1111, 32'h2222_2222);
    rd(5'd9);
    chk("rd9_both", {rd_base, rd_stride}, 64'h1111_1111_2222_2222);

    // Out-of-range address on the 24-entry instance.
    wr_both(5'd30, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    rd(5'd30);
    chk("d32_rd30_base", 64'(rd_base),   64'hDEAD_BEEF);
    chk("d24_rd30_vld",  64'(rd_valid2), 64'd1);
    chk("d24_rd30_data", {rd_base2, rd_stride2}, 64'd0);
    rd(5'd3);
    chk("d24_rd3", {rd_base2, rd_stride2}, 64'h0000_1234_FFFF_FFFC);
    rd(5'd7);
    chk("d24_rd7", 64'(rd_base2), 64'hA5A5_0001);

    // Fill every entry with nonzero data.
    for (int i = 0; i < 32; i++) wr_both(5'(i), 32'h100 + 32'(i), 32'hF000_0000 | 32'(i));
    rd(5'd31);
    chk("fill31", {rd_base, rd_stride}, 64'h0000_011F_F000_001F);

    // Clear request alongside a read: the read completes, the sweep starts.
    clear_req = 1; rd_req = 1; rd_addr = 5'd1;
    tick();
    chk("clr_start_busy", 64'(busy),     64'd1);
    chk("clr_start_vld",  64'(rd_valid), 64'd1);
    chk("clr_start_base", 64'(rd_base),  64'h101);
    // Keep a write to 5, a read and a repeated clear request up during the sweep.
    clear_req = 0;
    wr_base_req = 1; wr_base_addr = 5'd5; wr_base_data = 32'h5555_5555;
    rd_addr = 5'd4;
    n = 1;
    vld_seen = 0;
    for (int c = 0; c < 100; c++) begin
      clear_req = (c == 15);
      tick();
      if (rd_valid) vld_seen = 1;
      if (!busy) break;
      n++;
    end
    idle_inputs();
    chk("clr_len",   64'(n),        64'd32);
    chk("clr_novld", 64'(vld_seen), 64'd0);
    tick();
    chk("clr_idle_busy", 64'(busy), 64'd0);

    // Everything reads back as zero, including the dropped write to 5.
    for (int i = 0; i < 32; i++) begin
      rd(5'(i));
      chk($sformatf("zero_%0d", i), {rd_base, rd_stride}, 64'd0);
    end

    // Asynchronous reset in the middle of a sweep.
    wr_base_req = 1; wr_base_addr = 5'd2; wr_base_data = 32'h77;
    tick();
    idle_inputs();
    rd(5'd2);
    chk("pre_rst_base", 64'(rd_base), 64'h77);
    clear_req = 1;
    tick();
    idle_inputs();
    for (int c = 0; c < 10; c++) tick();
    chk("mid_sweep_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", 64'(busy),     64'd0);
    chk("arst_vld",  64'(rd_valid), 64'd0);
    chk("arst_data", {rd_base, rd_stride}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
    wr_both(5'd4, 32'h99, 32'h3);
    rd(5'd4);
    chk("post_rst_rd4",  {rd_base, rd_stride}, 64'h0000_0099_0000_0003);
    chk("post_rst_vld",  64'(rd_valid), 64'd1);
    rd(5'd2);
    chk("post_rst_rd2",  64'(rd_base), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
